// File: rtl/bkm_bus_master.sv
// -----------------------------------------------------------------------------
// bkm_bus_master
//   Single-slot card bus master. Accepts one read or write command at a time
//   and plays it out on the card bus as six equal-length phases:
//   address setup/strobe/hold and then data setup/strobe/hold. A one-clock DONE
//   state follows and raises rsp_valid. On the wire all address and data bits
//   are inverted. After module reset the card is held in bus reset for
//   BUS_RESET_CYCLES clocks before the first command is accepted.
//
// Ports
//   clk_50mhz_in  : single clock, rising edge
//   reset_x       : asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_wdata : command handshake
//   rsp_valid, rsp_rdata : completion pulse and read data (held until the
//                          next read completes)
//   slot_x_int_x, clk_rw, ax_d, r_wx, ad_out, ad_oe_x : bus outputs (registered)
//   ad_in         : bus sample
//   bus_reset_x   : active-low reset to the card
//   irq_x         : card interrupt (active-low, asynchronous)
//   irq_pending   : synchronised active-high interrupt level
// -----------------------------------------------------------------------------
module bkm_bus_master #(
   parameter int PHASE_CYCLES     = 25,
   parameter int BUS_RESET_CYCLES = 50
) (
   input  logic       clk_50mhz_in,
   input  logic       reset_x,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       slot_x_int_x,
   output logic       clk_rw,
   output logic       ax_d,
   output logic       r_wx,
   output logic [7:0] ad_out,
   output logic       ad_oe_x,
   input  logic [7:0] ad_in,
   output logic       bus_reset_x,
   input  logic       irq_x,
   output logic       irq_pending
);

   localparam logic [3:0] ST_BUSRST      = 4'd0;
   localparam logic [3:0] ST_IDLE        = 4'd1;
   localparam logic [3:0] ST_ADDR_SETUP  = 4'd2;
   localparam logic [3:0] ST_ADDR_STROBE = 4'd3;
   localparam logic [3:0] ST_ADDR_HOLD   = 4'd4;
   localparam logic [3:0] ST_DATA_SETUP  = 4'd5;
   localparam logic [3:0] ST_DATA_STROBE = 4'd6;
   localparam logic [3:0] ST_DATA_HOLD   = 4'd7;
   localparam logic [3:0] ST_DONE        = 4'd8;

   localparam logic [7:0]  C_PHASE_LOAD = 8'(PHASE_CYCLES - 1);
   localparam logic [15:0] C_BRST_LOAD  = 16'(BUS_RESET_CYCLES - 1);

   logic [3:0]  r_state;
   logic [7:0]  r_phase_cnt;
   logic [15:0] r_brst_cnt;
   logic        r_write;
   logic [7:0]  r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_cap;
   logic        r_cmd_ready;
   logic        r_rsp_valid;
   logic [7:0]  r_rsp_rdata;
   logic        r_slot;
   logic        r_clk_rw;
   logic        r_ax_d;
   logic        r_r_wx;
   logic [7:0]  r_ad_out;
   logic        r_ad_oe_x;
   logic        r_bus_reset_x;
   logic        r_irq_meta;
   logic        r_irq_sync;

   logic [3:0]  w_state_next;
   logic [7:0]  w_phase_next;
   logic [15:0] w_brst_next;
   logic        w_accept;
   logic        w_phase_last;
   logic        w_write_next;
   logic [7:0]  w_addr_next;
   logic [7:0]  w_wdata_next;
   logic        w_capture;
   logic        w_slot_next;
   logic        w_clk_rw_next;
   logic        w_ax_d_next;
   logic        w_r_wx_next;
   logic [7:0]  w_ad_out_next;
   logic        w_ad_oe_x_next;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_accept     = r_cmd_ready & cmd_valid;
      w_phase_last = (r_phase_cnt == 8'd0);
      w_state_next = r_state;
      w_brst_next  = r_brst_cnt;

      case (r_state)
         ST_BUSRST: begin
            if (r_brst_cnt == 16'd0) w_state_next = ST_IDLE;
            else                     w_brst_next  = r_brst_cnt - 16'd1;
         end
         ST_IDLE:        if (w_accept)     w_state_next = ST_ADDR_SETUP;
         ST_ADDR_SETUP:  if (w_phase_last) w_state_next = ST_ADDR_STROBE;
         ST_ADDR_STROBE: if (w_phase_last) w_state_next = ST_ADDR_HOLD;
         ST_ADDR_HOLD:   if (w_phase_last) w_state_next = ST_DATA_SETUP;
         ST_DATA_SETUP:  if (w_phase_last) w_state_next = ST_DATA_STROBE;
         ST_DATA_STROBE: if (w_phase_last) w_state_next = ST_DATA_HOLD;
         ST_DATA_HOLD:   if (w_phase_last) w_state_next = ST_DONE;
         ST_DONE:                          w_state_next = ST_IDLE;
         default:                          w_state_next = ST_BUSRST;
      endcase

      // Reload on every state change so each phase starts from a full count;
      // otherwise count down and park at zero.
      if (w_state_next != r_state)  w_phase_next = C_PHASE_LOAD;
      else if (!w_phase_last)       w_phase_next = r_phase_cnt - 8'd1;
      else                          w_phase_next = r_phase_cnt;

      w_write_next = w_accept ? cmd_write : r_write;
      w_addr_next  = w_accept ? cmd_addr  : r_addr;
      w_wdata_next = w_accept ? cmd_wdata : r_wdata;

      // Sample on the edge that ends the data strobe.
      w_capture = (r_state == ST_DATA_STROBE) && (w_state_next == ST_DATA_HOLD) && !r_write;
   end

   // -------------------------------------------------------------------------
   // Bus output decode from the NEXT state, so that the registered outputs
   // change on the same edge as the state and are glitch-free.
   // -------------------------------------------------------------------------
   always_comb begin
      w_slot_next    = 1'b1;
      w_clk_rw_next  = 1'b1;
      w_ax_d_next    = 1'b1;
      w_r_wx_next    = 1'b1;
      w_ad_out_next  = 8'hFF;
      w_ad_oe_x_next = 1'b1;

      case (w_state_next)
         ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
            w_slot_next    = 1'b0;
            w_clk_rw_next  = (w_state_next != ST_ADDR_STROBE);
            w_ax_d_next    = 1'b0;
            w_r_wx_next    = 1'b0;
            w_ad_out_next  = ~w_addr_next;
            w_ad_oe_x_next = 1'b0;
         end
         ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
            w_slot_next   = 1'b0;
            w_clk_rw_next = (w_state_next != ST_DATA_STROBE);
            w_ax_d_next   = 1'b1;
            w_r_wx_next   = ~w_write_next;
            if (w_write_next) begin
               w_ad_out_next  = ~w_wdata_next;
               w_ad_oe_x_next = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         r_state       <= ST_BUSRST;
         r_phase_cnt   <= C_PHASE_LOAD;
         r_brst_cnt    <= C_BRST_LOAD;
         r_write       <= 1'b0;
         r_addr        <= 8'h00;
         r_wdata       <= 8'h00;
         r_cap         <= 8'h00;
         r_cmd_ready   <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= 8'h00;
         r_slot        <= 1'b1;
         r_clk_rw      <= 1'b1;
         r_ax_d        <= 1'b1;
         r_r_wx        <= 1'b1;
         r_ad_out      <= 8'hFF;
         r_ad_oe_x     <= 1'b1;
         r_bus_reset_x <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_phase_cnt   <= w_phase_next;
         r_brst_cnt    <= w_brst_next;
         r_write       <= w_write_next;
         r_addr        <= w_addr_next;
         r_wdata       <= w_wdata_next;
         r_cmd_ready   <= (w_state_next == ST_IDLE);
         r_rsp_valid   <= (w_state_next == ST_DONE);
         r_slot        <= w_slot_next;
         r_clk_rw      <= w_clk_rw_next;
         r_ax_d        <= w_ax_d_next;
         r_r_wx        <= w_r_wx_next;
         r_ad_out      <= w_ad_out_next;
         r_ad_oe_x     <= w_ad_oe_x_next;
         r_bus_reset_x <= (w_state_next != ST_BUSRST);
         if (w_capture) r_cap <= ad_in;
         if ((w_state_next == ST_DONE) && !r_write) r_rsp_rdata <= ~r_cap;
      end
   end

   // Interrupt synchroniser; resets to the inactive (high) line level.
   always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
      if (!reset_x) begin
         r_irq_meta <= 1'b1;
         r_irq_sync <= 1'b1;
      end else begin
         r_irq_meta <= irq_x;
         r_irq_sync <= r_irq_meta;
      end
   end

   assign cmd_ready    = r_cmd_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_rdata    = r_rsp_rdata;
   assign slot_x_int_x = r_slot;
   assign clk_rw       = r_clk_rw;
   assign ax_d         = r_ax_d;
   assign r_wx         = r_r_wx;
   assign ad_out       = r_ad_out;
   assign ad_oe_x      = r_ad_oe_x;
   assign bus_reset_x  = r_bus_reset_x;
   assign irq_pending  = ~r_irq_sync;

endmodule

// File: tb/tb_bkm_bus_master.sv
// -----------------------------------------------------------------------------
// tb_bkm_bus_master
//   Scoreboard bench: the driver pushes each accepted command (with its
//   acceptance cycle) into a queue; the monitor derives the expected bus
//   waveform from elapsed cycles since acceptance and checks rsp_valid/rdata.
// -----------------------------------------------------------------------------
module tb_bkm_bus_master;

   localparam int P   = 4;
   localparam int BRC = 50;
   localparam int LAT = 6 * P + 1;
   localparam int GAP = 6 * P + 2;

   logic       clk = 1'b0;
   logic       reset_x = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe_x, bus_reset_x, irq_pending;
   logic [7:0] ad_out;
   logic [7:0] ad_in = 8'h00;
   logic       irq_x = 1'b1;

   bkm_bus_master #(.PHASE_CYCLES(P), .BUS_RESET_CYCLES(BRC)) dut (
      .clk_50mhz_in(clk), .reset_x(reset_x),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .slot_x_int_x(slot_x_int_x), .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx),
      .ad_out(ad_out), .ad_oe_x(ad_oe_x), .ad_in(ad_in),
      .bus_reset_x(bus_reset_x), .irq_x(irq_x), .irq_pending(irq_pending)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         acc;
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] adval;
   } txn_t;

   txn_t       q[$];
   logic [7:0] last_rdata = 8'h00;
   bit         mon_en = 1'b0;
   int         prev_acc = -1;
   int         n_checks = 0;
   int         n_fail = 0;
   int         n_txn = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Card model: present the read value only while the data strobe is low.
   initial begin
      forever begin
         @(negedge clk);
         if (!clk_rw && ax_d && r_wx && q.size() > 0) ad_in = q[0].adval;
         else                                        ad_in = 8'($urandom);
      end
   end

   // Monitor: expected outputs from cycles elapsed since acceptance.
   initial begin : monitor
      int k, p;
      logic e_cr, e_rv, e_slot, e_crw, e_axd, e_rwx, e_oe, mask_ad, done;
      logic [7:0] e_ad;
      logic [23:0] act_v, exp_v;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            e_cr = 1'b1; e_rv = 1'b0; e_slot = 1'b1; e_crw = 1'b1; e_axd = 1'b1;
            e_rwx = 1'b1; e_oe = 1'b1; e_ad = 8'hFF; mask_ad = 1'b0; done = 1'b0;
            k = -1;
            if (q.size() > 0 && cyc >= q[0].acc) begin
               k = cyc - q[0].acc;
               e_cr = 1'b0;
               if (k < 6 * P) begin
                  p = k / P;
                  e_slot = 1'b0;
                  e_crw  = (p == 1 || p == 4) ? 1'b0 : 1'b1;
                  if (p < 3) begin
                     e_axd = 1'b0; e_rwx = 1'b0; e_ad = ~q[0].addr; e_oe = 1'b0;
                  end else begin
                     e_axd = 1'b1; e_rwx = ~q[0].wr;
                     if (q[0].wr) begin e_ad = ~q[0].wdata; e_oe = 1'b0; end
                     else         begin e_oe = 1'b1; mask_ad = 1'b1; end
                  end
               end else begin
                  e_rv = 1'b1;
                  done = 1'b1;
                  if (!q[0].wr) last_rdata = ~q[0].adval;
               end
            end
            act_v = {cmd_ready, rsp_valid, bus_reset_x, slot_x_int_x, clk_rw, ax_d, r_wx,
                     ad_oe_x, (mask_ad ? 8'h00 : ad_out), rsp_rdata};
            exp_v = {e_cr, e_rv, 1'b1, e_slot, e_crw, e_axd, e_rwx, e_oe,
                     (mask_ad ? 8'h00 : e_ad), last_rdata};
            check($sformatf("bus_k%0d", k), 32'(act_v), 32'(exp_v));
            if (done) begin
               check("rsp_latency", rsp_valid ? 32'(k + 1) : 32'hFFFF_FFFF, 32'(LAT));
               n_txn++;
               $display("txn %0d: %s addr=%h wdata=%h rdata=%h (exp %h) acc_cyc=%0d",
                        n_txn, q[0].wr ? "WR" : "RD", q[0].addr, q[0].wdata,
                        rsp_rdata, last_rdata, q[0].acc);
               void'(q.pop_front());
            end
         end
      end
   end

   // Issue one command; returns at the negedge just after acceptance.
   task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] av, input bit hold);
      int budget = 0;
      txn_t t;
      while (!cmd_ready && budget < 300) begin
         cmd_valid = hold ? 1'b1 : 1'($urandom);
         cmd_write = 1'($urandom);
         cmd_addr  = 8'($urandom);
         cmd_wdata = 8'($urandom);
         @(negedge clk);
         budget++;
      end
      if (!cmd_ready) begin
         check("ready_timeout", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b0;
         return;
      end
      if (!hold) begin
         cmd_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      t.acc = cyc + 1; t.wr = wr; t.addr = a; t.wdata = d; t.adval = av;
      q.push_back(t);
      if (hold && prev_acc >= 0) check("b2b_spacing", 32'(t.acc - prev_acc), 32'(GAP));
      prev_acc = t.acc;
      @(negedge clk);
   endtask

   // Release reset at a negedge and measure the bus-reset window.
   task automatic busrst_check();
      int  cnt = 0;
      bit  bad = 1'b0;
      reset_x = 1'b1;
      while (!bus_reset_x && cnt < BRC + 20) begin
         if (cmd_ready || rsp_valid) bad = 1'b1;
         cnt++;
         @(negedge clk);
      end
      check("busrst_len", 32'(cnt), 32'(BRC));
      check("busrst_no_activity", 32'(bad), 32'd0);
      check("ready_after_busrst", 32'(cmd_ready), 32'd1);
   endtask

   task automatic wait_drain();
      int budget = 0;
      cmd_valid = 1'b0;
      while (q.size() > 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   task automatic irq_check(input logic level, input string name);
      int cnt = 0;
      @(posedge clk);
      #3 irq_x = level;
      while (irq_pending !== ~level && cnt < 10) begin
         @(posedge clk);
         #1 cnt++;
      end
      n_checks++;
      if (!(cnt inside {[2:3]})) begin
         n_fail++;
         $display("FAIL %s: latency %0d clocks, required 2..3", name, cnt);
      end
   endtask

   initial begin
      int budget;
      #1 reset_x = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bus_reset_x", 32'(bus_reset_x), 32'd0);
      check("rst_cmd_ready",   32'(cmd_ready),   32'd0);
      check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
      check("rst_rsp_rdata",   32'(rsp_rdata),   32'h00);
      check("rst_irq_pending", 32'(irq_pending), 32'd0);
      check("rst_bus_idle", 32'({slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe_x, ad_out}),
            32'({5'b11111, 8'hFF}));

      busrst_check();
      mon_en = 1'b1;

      // Directed write then read, then a held-valid back-to-back pair.
      issue(1'b1, 8'h12, 8'hA5, 8'h00, 1'b0);
      issue(1'b0, 8'h03, 8'h77, 8'h3C, 1'b0);
      issue(1'b1, 8'h5E, 8'h0F, 8'h00, 1'b1);
      issue(1'b0, 8'hC1, 8'h00, 8'h96, 1'b1);

      for (int i = 0; i < 30; i++)
         issue(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      wait_drain();
      check("rdata_after_drain", 32'(rsp_rdata), 32'(last_rdata));

      // Reset in the middle of a read's data strobe.
      issue(1'b0, 8'h44, 8'h00, 8'h81, 1'b0);
      cmd_valid = 1'b0;
      budget = 0;
      while (!(!clk_rw && ax_d) && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      check("reach_data_strobe", 32'({clk_rw, ax_d}), 32'b01);
      mon_en = 1'b0;
      #3 reset_x = 1'b0;
      #1;
      check("midrst_bus_idle", 32'({slot_x_int_x, clk_rw, ax_d, r_wx, ad_oe_x, ad_out}),
            32'({5'b11111, 8'hFF}));
      check("midrst_ctrl", 32'({bus_reset_x, cmd_ready, rsp_valid, rsp_rdata}), 32'h0);
      q.delete();
      last_rdata = 8'h00;
      prev_acc = -1;
      repeat (2) @(negedge clk);
      busrst_check();
      mon_en = 1'b1;
      issue(1'b0, 8'h2B, 8'h00, 8'h5A, 1'b0);
      issue(1'b1, 8'hFE, 8'h01, 8'h00, 1'b1);
      wait_drain();

      irq_check(1'b0, "irq_set_latency");
      repeat (3) @(posedge clk);
      irq_check(1'b1, "irq_clear_latency");

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
